// File: rtl/mips_ctrl_fsm_pkg.sv
// Shared definitions for the MIPS-style control unit: opcode values,
// ALU-control codes, FSM state encoding and the control-strobe bundle.
package mips_ctrl_fsm_pkg;

  localparam int unsigned OPC_BASE_W  = 3;
  localparam int unsigned ALUC_BASE_W = 2;

  // Opcode values (upper OPC_W bits of the instruction word)
  localparam logic [OPC_BASE_W-1:0] OPC_LI   = 3'b000;
  localparam logic [OPC_BASE_W-1:0] OPC_LW   = 3'b001;
  localparam logic [OPC_BASE_W-1:0] OPC_SW   = 3'b010;
  localparam logic [OPC_BASE_W-1:0] OPC_ADDI = 3'b011;
  localparam logic [OPC_BASE_W-1:0] OPC_BEQ  = 3'b100;
  localparam logic [OPC_BASE_W-1:0] OPC_SLTI = 3'b101;
  localparam logic [OPC_BASE_W-1:0] OPC_ADD  = 3'b110;
  localparam logic [OPC_BASE_W-1:0] OPC_J    = 3'b111;

  // ALU-control codes; zero-extended when the ALU-control field is wider
  localparam logic [ALUC_BASE_W-1:0] ALUC_ADD = 2'b00;
  localparam logic [ALUC_BASE_W-1:0] ALUC_SUB = 2'b01;
  localparam logic [ALUC_BASE_W-1:0] ALUC_SLT = 2'b10;

  // S_LI_LO: upper half of li issued, lower half expected next
  typedef enum logic {
    S_NORM  = 1'b0,
    S_LI_LO = 1'b1
  } state_t;

  typedef struct packed {
    logic alu_src;
    logic mem_to_reg;
    logic reg_write;
    logic mem_write;
    logic branch;
    logic jump;
    logic m_sel;
  } ctrl_strb_t;

  localparam ctrl_strb_t CTRL_NONE = '0;

endpackage

// File: rtl/mips_ctrl_fsm_dec.sv
// Combinational opcode decoder.
// Ports: i_opcode  - opcode field of the instruction
//        i_li_lo   - 1 when an li would be the lower half
//        o_strb    - control strobes
//        o_alu_ctrl- ALU operation select
module mips_ctrl_dec
  import mips_ctrl_fsm_pkg::*;
#(
  parameter int unsigned OPC_W  = 3,
  parameter int unsigned ALUC_W = 2
) (
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic              i_li_lo,
  output ctrl_strb_t        o_strb,
  output logic [ALUC_W-1:0] o_alu_ctrl
);

  always_comb begin
    o_strb     = CTRL_NONE;
    o_alu_ctrl = '0;
    case (i_opcode)
      OPC_W'(OPC_LI): begin
        o_strb.alu_src    = 1'b1;
        o_strb.mem_to_reg = 1'b1;
        o_strb.reg_write  = 1'b1;
        o_strb.m_sel      = 1'b1;
        // Upper half is flagged with an all-ones ALU code, lower half with 0
        o_alu_ctrl        = i_li_lo ? '0 : '1;
      end
      OPC_W'(OPC_LW): begin
        o_strb.alu_src    = 1'b1;
        o_strb.mem_to_reg = 1'b1;
        o_strb.reg_write  = 1'b1;
        o_alu_ctrl        = ALUC_W'(ALUC_ADD);
      end
      OPC_W'(OPC_SW): begin
        o_strb.alu_src    = 1'b1;
        o_strb.mem_write  = 1'b1;
        o_alu_ctrl        = ALUC_W'(ALUC_ADD);
      end
      OPC_W'(OPC_ADDI): begin
        o_strb.alu_src    = 1'b1;
        o_strb.reg_write  = 1'b1;
        o_alu_ctrl        = ALUC_W'(ALUC_ADD);
      end
      OPC_W'(OPC_BEQ): begin
        o_strb.branch     = 1'b1;
        o_alu_ctrl        = ALUC_W'(ALUC_SUB);
      end
      OPC_W'(OPC_SLTI): begin
        o_strb.alu_src    = 1'b1;
        o_strb.reg_write  = 1'b1;
        o_alu_ctrl        = ALUC_W'(ALUC_SLT);
      end
      OPC_W'(OPC_ADD): begin
        o_strb.reg_write  = 1'b1;
        o_alu_ctrl        = ALUC_W'(ALUC_ADD);
      end
      OPC_W'(OPC_J): begin
        o_strb.jump       = 1'b1;
      end
      default: begin
        o_strb     = CTRL_NONE;
        o_alu_ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Control unit: li-sequencing FSM plus registered control outputs with
// stall/flush/bubble handling.
// Ports: clk, reset (sync, active-high); instr_valid/instr - instruction in;
//        stall - hold everything; flush - bubble and abort li;
//        alu_src..jump, alu_ctrl - registered controls;
//        ctrl_valid - controls belong to an accepted instruction;
//        li_pending - li upper half done; li_err - broken li sequence pulse.
module mips_ctrl_fsm
  import mips_ctrl_fsm_pkg::*;
#(
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned OPC_W   = 3,
  parameter int unsigned ALUC_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic               stall,
  input  logic               flush,
  output logic               alu_src,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               mem_write,
  output logic               branch,
  output logic               m_sel,
  output logic               jump,
  output logic [ALUC_W-1:0]  alu_ctrl,
  output logic               ctrl_valid,
  output logic               li_pending,
  output logic               li_err
);

  state_t              r_state;
  ctrl_strb_t          r_strb;
  logic [ALUC_W-1:0]   r_alu_ctrl;
  logic                r_ctrl_valid;
  logic                r_li_err;

  logic [OPC_W-1:0]    w_opcode;
  logic                w_li_lo;
  logic                w_is_li;
  ctrl_strb_t          w_dec_strb;
  logic [ALUC_W-1:0]   w_dec_alu;
  logic                w_unused_lo;

  assign w_opcode    = instr[INSTR_W-1 -: OPC_W];
  // Operand bits never influence decode
  assign w_unused_lo = ^instr[INSTR_W-OPC_W-1:0];
  assign w_li_lo     = (r_state == S_LI_LO);
  assign w_is_li     = (w_opcode == OPC_W'(OPC_LI));

  mips_ctrl_dec #(
    .OPC_W  (OPC_W),
    .ALUC_W (ALUC_W)
  ) u_dec (
    .i_opcode   (w_opcode),
    .i_li_lo    (w_li_lo),
    .o_strb     (w_dec_strb),
    .o_alu_ctrl (w_dec_alu)
  );

  // FSM and output register; priority reset > flush > stall > instr_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_NORM;
      r_strb       <= CTRL_NONE;
      r_alu_ctrl   <= '0;
      r_ctrl_valid <= 1'b0;
      r_li_err     <= 1'b0;
    end else if (flush) begin
      r_state      <= S_NORM;
      r_strb       <= CTRL_NONE;
      r_alu_ctrl   <= '0;
      r_ctrl_valid <= 1'b0;
      r_li_err     <= w_li_lo;
    end else if (!stall) begin
      if (instr_valid) begin
        r_strb       <= w_dec_strb;
        r_alu_ctrl   <= w_dec_alu;
        r_ctrl_valid <= 1'b1;
        // Anything but the lower-half li breaks a pending sequence
        r_li_err     <= w_li_lo && !w_is_li;
        r_state      <= (w_is_li && !w_li_lo) ? S_LI_LO : S_NORM;
      end else begin
        r_strb       <= CTRL_NONE;
        r_alu_ctrl   <= '0;
        r_ctrl_valid <= 1'b0;
        r_li_err     <= 1'b0;
      end
    end
  end

  assign alu_src    = r_strb.alu_src;
  assign mem_to_reg = r_strb.mem_to_reg;
  assign reg_write  = r_strb.reg_write;
  assign mem_write  = r_strb.mem_write;
  assign branch     = r_strb.branch;
  assign jump       = r_strb.jump;
  assign m_sel      = r_strb.m_sel;
  assign alu_ctrl   = r_alu_ctrl;
  assign ctrl_valid = r_ctrl_valid;
  assign li_pending = (r_state == S_LI_LO);
  assign li_err     = r_li_err;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Bench for mips_ctrl_fsm: default instance plus a wide (INSTR_W=16,
// ALUC_W=3) instance sharing stimulus, checked against a behavioural model.
module tb_mips_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rs, fl, st, v;
  logic [7:0]  ins;
  logic [7:0]  lo8;
  logic [15:0] ins16;
  assign ins16 = {ins, lo8};

  wire  [6:0]  s1, s2;
  wire  [1:0]  a_alu;
  wire  [2:0]  b_alu;
  wire         a_valid, a_pend, a_err, b_valid, b_pend, b_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // s = {alu_src, mem_to_reg, reg_write, mem_write, branch, jump, m_sel}
  mips_ctrl_fsm u_d1 (
    .clk(clk), .reset(rs), .instr_valid(v), .instr(ins), .stall(st), .flush(fl),
    .alu_src(s1[6]), .mem_to_reg(s1[5]), .reg_write(s1[4]), .mem_write(s1[3]),
    .branch(s1[2]), .jump(s1[1]), .m_sel(s1[0]), .alu_ctrl(a_alu),
    .ctrl_valid(a_valid), .li_pending(a_pend), .li_err(a_err)
  );

  mips_ctrl_fsm #(.INSTR_W(16), .OPC_W(3), .ALUC_W(3)) u_d2 (
    .clk(clk), .reset(rs), .instr_valid(v), .instr(ins16), .stall(st), .flush(fl),
    .alu_src(s2[6]), .mem_to_reg(s2[5]), .reg_write(s2[4]), .mem_write(s2[3]),
    .branch(s2[2]), .jump(s2[1]), .m_sel(s2[0]), .alu_ctrl(b_alu),
    .ctrl_valid(b_valid), .li_pending(b_pend), .li_err(b_err)
  );

  // Behavioural model: opcode tables plus an "upper half seen" flag
  bit       m_known = 1'b0;
  bit       m_half  = 1'b0;
  bit [6:0] m_strb;
  int       m_code;
  bit       m_hi, m_valid, m_err;

  function automatic bit [6:0] strb_of(int op);
    case (op)
      0: return 7'b1110001;
      1: return 7'b1110000;
      2: return 7'b1001000;
      3: return 7'b1010000;
      4: return 7'b0000100;
      5: return 7'b1010000;
      6: return 7'b0010000;
      default: return 7'b0000010;
    endcase
  endfunction

  function automatic int code_of(int op);
    if (op == 4) return 1;
    if (op == 5) return 2;
    return 0;
  endfunction

  function automatic int exp_alu(int w);
    return m_hi ? ((1 << w) - 1) : m_code;
  endfunction

  task automatic bubble();
    m_strb = '0; m_code = 0; m_hi = 1'b0; m_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rs) begin
      m_known = 1'b1; m_half = 1'b0; m_err = 1'b0;
      bubble();
    end else if (!m_known || st && !fl) begin
      // nothing known yet, or stalled: everything holds
    end else if (fl) begin
      m_err = m_half; m_half = 1'b0;
      bubble();
    end else if (v) begin
      int op;
      op      = int'(ins[7:5]);
      m_strb  = strb_of(op);
      m_valid = 1'b1;
      if (op == 0) begin
        m_hi   = !m_half;
        m_code = 0;
        m_err  = 1'b0;
        m_half = !m_half;
      end else begin
        m_hi   = 1'b0;
        m_code = code_of(op);
        m_err  = m_half;
        m_half = 1'b0;
      end
    end else begin
      m_err = 1'b0;
      bubble();
    end
  end

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_known) begin
      cmp("d1_ctrl", int'({s1, a_valid, a_pend, a_err}), int'({m_strb, m_valid, m_half, m_err}));
      cmp("d1_alu", int'(a_alu), exp_alu(2));
      cmp("d2_ctrl", int'({s2, b_valid, b_pend, b_err}), int'({m_strb, m_valid, m_half, m_err}));
      cmp("d2_alu", int'(b_alu), exp_alu(3));
    end
  end

  // Drive one cycle of inputs, return 1 time unit after the edge
  task automatic cyc(input logic r, input logic f, input logic s, input logic vv,
                     input logic [2:0] op);
    rs = r; fl = f; st = s; v = vv;
    ins = {op, 5'(($urandom))};
    lo8 = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rs = 1'b1; fl = 1'b0; st = 1'b0; v = 1'b0; ins = '0; lo8 = '0;
    cyc(1, 0, 0, 1, 3'b001);
    cmp("rst_valid", int'(a_valid), 0);
    cmp("rst_strb", int'(s1), 0);
    cmp("rst_pend", int'(a_pend), 0);

    cyc(0, 0, 0, 1, 3'b001);                         // lw
    cmp("lw_valid", int'(a_valid), 1);
    cmp("lw_strb", int'(s1), 7'b1110000);
    cmp("lw_alu", int'(a_alu), 0);

    cyc(0, 0, 0, 1, 3'b000);                         // li upper
    cmp("li1_alu", int'(a_alu), 3);
    cmp("li1_msel", int'(s1[0]), 1);
    cmp("li1_pend", int'(a_pend), 1);
    cyc(0, 0, 0, 1, 3'b000);                         // li lower
    cmp("li2_alu", int'(a_alu), 0);
    cmp("li2_pend", int'(a_pend), 0);
    cmp("li2_err", int'(a_err), 0);

    cyc(0, 0, 0, 1, 3'b000);
    cyc(0, 0, 0, 1, 3'b100);                         // beq breaks li
    cmp("beq_branch", int'(s1[2]), 1);
    cmp("beq_alu", int'(a_alu), 1);
    cmp("beq_err", int'(a_err), 1);
    cmp("beq_pend", int'(a_pend), 0);
    cyc(0, 0, 0, 1, 3'b000);                         // fresh upper half
    cmp("li_after_alu", int'(a_alu), 3);

    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 3'($urandom));
      cmp("stall_alu", int'(a_alu), 3);
      cmp("stall_pend", int'(a_pend), 1);
    end
    cyc(0, 0, 0, 1, 3'b000);
    cmp("post_stall_alu", int'(a_alu), 0);
    cmp("post_stall_err", int'(a_err), 0);

    cyc(0, 0, 0, 1, 3'b000);
    cyc(0, 1, 0, 1, 3'b000);                         // flush mid-li
    cmp("flush_valid", int'(a_valid), 0);
    cmp("flush_err", int'(a_err), 1);
    cmp("flush_pend", int'(a_pend), 0);
    cyc(0, 0, 0, 1, 3'b000);
    cyc(1, 1, 1, 1, 3'b001);                         // reset mid-li
    cmp("rst_li_err", int'(a_err), 0);
    cmp("rst_li_pend", int'(a_pend), 0);

    cyc(0, 0, 0, 0, 3'b011);                         // bubble
    cmp("bubble_valid", int'(a_valid), 0);
    cmp("bubble_strb", int'(s1), 0);

    cyc(0, 0, 0, 1, 3'b111);                         // wide instance: j, slti, li
    cmp("w_j_jump", int'(s2[1]), 1);
    cmp("w_j_alu", int'(b_alu), 0);
    cyc(0, 0, 0, 1, 3'b101);
    cmp("w_slti_alu", int'(b_alu), 2);
    cmp("w_slti_rw", int'(s2[4]), 1);
    cyc(0, 0, 0, 1, 3'b000);
    cmp("w_li_alu", int'(b_alu), 7);

    for (int i = 0; i < 4000; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 99) < 35) ? 3'b000 : 3'($urandom);
      cyc(logic'($urandom_range(0, 99) < 2), logic'($urandom_range(0, 99) < 7),
          logic'($urandom_range(0, 99) < 15), logic'($urandom_range(0, 99) < 75), op);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_ctrl_fsm.md
MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

Interface
REQ-001 SHALL have parameter INSTR_W, default 8: instruction width in bits.
REQ-002 SHALL have parameter OPC_W, default 3: opcode width, taken from instr[INSTR_W-1 -: OPC_W].
REQ-003 SHALL have parameter ALUC_W, default 2: ALU-control width.
REQ-004 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-005 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-006 SHALL have port instr_valid, input, 1: instr holds an instruction to decode this cycle.
REQ-007 SHALL have port instr, input, INSTR_W: instruction word.
REQ-008 SHALL have port stall, input, 1: freeze all state and outputs.
REQ-009 SHALL have port flush, input, 1: squash the pending decode and abort any li sequence.
REQ-010 SHALL have outputs alu_src, mem_to_reg, reg_write, mem_write, branch, m_sel and jump, each 1 bit, each a registered control strobe.
REQ-011 SHALL have output alu_ctrl, ALUC_W: registered ALU operation select.
REQ-012 SHALL have output ctrl_valid, 1: the control outputs describe an accepted instruction.
REQ-013 SHALL have output li_pending, 1: the upper half of li is done and the lower half is expected.
REQ-014 SHALL have output li_err, 1: one-cycle pulse when a li sequence is broken.

Function
REQ-015 An instruction SHALL be accepted when instr_valid=1, stall=0, flush=0 and reset=0.
- Its controls appear on the outputs one clk after acceptance.
- ctrl_valid=1 for that cycle.
REQ-016 Control decode per opcode (alu_src, mem_to_reg, reg_write, mem_write, branch, jump, m_sel, alu_ctrl):
- 000 li: see REQ-018 and REQ-019.
- 001 lw: 1,1,1,0,0,0,0,00.
- 010 sw: 1,0,0,1,0,0,0,00.
- 011 addi: 1,0,1,0,0,0,0,00.
- 100 beq: 0,0,0,0,1,0,0,01.
- 101 slti: 1,0,1,0,0,0,0,10.
- 110 add: 0,0,1,0,0,0,0,00.
- 111 j: 0,0,0,0,0,1,0,00.
REQ-017 Don't-care fields SHALL be driven 0, never Z or X.
REQ-018 The FSM SHALL have two states, S_NORM and S_LI_LO. Accepting li in S_NORM:
- outputs 1,1,1,0,0,0,1 with alu_ctrl all-ones;
- next state S_LI_LO.
REQ-019 Accepting li in S_LI_LO:
- outputs 1,1,1,0,0,0,1 with alu_ctrl 0;
- next state S_NORM.
REQ-020 Accepting a non-li opcode in S_LI_LO:
- decode it normally per REQ-016;
- pulse li_err for that output cycle;
- next state S_NORM.
REQ-021 When instr_valid=0 and stall=0, the next cycle SHALL be a bubble: all strobes 0, alu_ctrl 0, ctrl_valid 0, FSM state held.
REQ-022 While stall=1, all outputs and the FSM state SHALL hold their values, and instr SHALL be ignored.
REQ-023 flush=1 (and reset=0) SHALL have this effect next cycle:
- a bubble;
- state S_NORM;
- li_err=1 if the state was S_LI_LO, otherwise 0.
REQ-024 Priority SHALL be reset > flush > stall > instr_valid.
REQ-025 li_pending SHALL equal (state == S_LI_LO).
- It is registered.
- It is visible in the same cycle as the upper-half li outputs.
REQ-026 Opcode bits below the OPC_W field SHALL NOT affect decode.
REQ-027 When ALUC_W>2, the codes listed SHALL be zero-extended, except that the li upper-half code is all-ones.

Reset
REQ-028 On reset=1 at a clk edge, next cycle:
- all strobes 0, alu_ctrl 0;
- ctrl_valid 0, li_pending 0, li_err 0;
- state S_NORM.
REQ-029 Reset SHALL override stall and flush.
- A reset asserted mid-li SHALL NOT raise li_err.

Structure
REQ-030 A shared package SHALL hold:
- opcode constants;
- the ALU-control code constants;
- the FSM state enum;
- a packed control-bundle struct.
REQ-031 A combinational sub-module mips_ctrl_dec SHALL map opcode plus li phase to the control bundle.
- The top level SHALL contain only the FSM, the output register, and the stall/flush/bubble muxing.

Verification
REQ-032 Reset then lw (instr=8'b001_00000, valid=1): one cycle later, ctrl_valid=1, alu_src=1, mem_to_reg=1, reg_write=1, alu_ctrl=00.
REQ-033 li, li back-to-back:
- cycle 1: alu_ctrl=11, m_sel=1, li_pending=1;
- cycle 2: alu_ctrl=00, li_pending=0, li_err=0.
REQ-034 li then beq:
- second output cycle: branch=1, alu_ctrl=01, li_err=1, li_pending=0;
- a following li decodes as the upper half (alu_ctrl=11).
REQ-035 li, then stall=1 for 3 cycles with instr changing, then li:
- outputs and li_pending held during the stall;
- the second li yields alu_ctrl=00.
REQ-036 li then flush=1: next cycle ctrl_valid=0, li_err=1, li_pending=0; reset asserted mid-li gives li_err=0.
REQ-037 Parameter INSTR_W=16, ALUC_W=3 with j (opcode 111) and slti: jump=1 with alu_ctrl=000, then alu_ctrl=010 with reg_write=1.
